instr_issue_unit: RTL and testbench

//  Instruction sequencer for the 4-bit Decode_And_Execute ALU. Holds a small program memory
//  and a 4x4-bit register file. Fetches each instruction, drives sel/rs/rt to the ALU,

---
 rtl/instr_issue_unit.sv | 131 +++++++++++++
 tb/tb_instr_issue_unit.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// Instruction sequencer for the 4-bit ALU: program memory, 4x4 register file, fetch/issue/writeback FSM.
// Optional single-step mode is enabled by defining SINGLE_STEP_EN.
module instr_issue_unit #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          rst_n,
`ifdef SINGLE_STEP_EN
  input  logic          step,
`endif
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [8:0]    prog_data,
  input  logic          reg_we,
  input  logic [1:0]    reg_waddr,
  input  logic [3:0]    reg_wdata,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [2:0]    alu_sel,
  output logic [3:0]    alu_rs,
  output logic [3:0]    alu_rt,
  input  logic [3:0]    alu_rd,
  output logic          busy,
  output logic          done,
  input  logic [1:0]    dbg_addr,
  output logic [3:0]    dbg_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WB, S_DONE
`ifdef SINGLE_STEP_EN
    , S_STALL
`endif
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc;
  logic [8:0]    ir;
  logic [AW:0]   len;
  logic [3:0]    regs [4];
  logic [8:0]    imem [DEPTH];
  logic [AW:0]   len_clamped;
  logic          last;

  assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  // Only meaningful in WB, where len is at least 1.
  assign last        = ({1'b0, pc} == (len - 1'b1));
  assign dbg_data    = regs[dbg_addr];

`ifdef SINGLE_STEP_EN
  logic last_q;
`endif

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = (prog_len == '0) ? S_DONE : S_FETCH;
      S_FETCH: begin busy = 1'b1; state_nxt = S_ISSUE; end
      S_ISSUE: begin busy = 1'b1; state_nxt = S_WB; end
      S_WB: begin
        busy = 1'b1;
`ifdef SINGLE_STEP_EN
        state_nxt = S_STALL;
`else
        state_nxt = last ? S_DONE : S_FETCH;
`endif
      end
`ifdef SINGLE_STEP_EN
      S_STALL: begin
        busy = 1'b1;
        if (step) state_nxt = last_q ? S_DONE : S_FETCH;
      end
`endif
      S_DONE:  begin done = 1'b1; state_nxt = S_IDLE; end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Program memory keeps its contents across reset.
  always_ff @(posedge CLK) begin
    if (state == S_IDLE && prog_we) imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      len     <= '0;
      alu_sel <= '0;
      alu_rs  <= '0;
      alu_rt  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef SINGLE_STEP_EN
      last_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (reg_we) regs[reg_waddr] <= reg_wdata;
          if (start) begin
            len <= len_clamped;
            pc  <= '0;
          end
        end
        S_FETCH: ir <= imem[pc];
        S_ISSUE: begin
          alu_sel <= ir[8:6];
          alu_rs  <= regs[ir[3:2]];
          alu_rt  <= regs[ir[1:0]];
        end
        S_WB: begin
          regs[ir[5:4]] <= alu_rd;
          pc            <= pc + 1'b1;
`ifdef SINGLE_STEP_EN
          last_q        <= last;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issue_unit.sv
// Directed self-checking bench for instr_issue_unit; a small behavioural ALU closes the loop.
module tb_instr_issue_unit;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [8:0] prog_data = '0;
  logic       reg_we = 1'b0;
  logic [1:0] reg_waddr = '0;
  logic [3:0] reg_wdata = '0;
  logic       start = 1'b0;
  logic [4:0] prog_len = '0;
  logic [2:0] alu_sel;
  logic [3:0] alu_rs, alu_rt, alu_rd;
  logic       busy, done;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  instr_issue_unit #(.DEPTH(16), .AW(4)) dut (
    .CLK(CLK), .rst_n(rst_n),
`ifdef SINGLE_STEP_EN
    .step(step),
`endif
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .start(start), .prog_len(prog_len),
    .alu_sel(alu_sel), .alu_rs(alu_rs), .alu_rt(alu_rt), .alu_rd(alu_rd),
    .busy(busy), .done(done), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural execute unit
  always_comb begin
    alu_rd = '0;
    case (alu_sel)
      3'b000: alu_rd = alu_rs + alu_rt;
      3'b001: alu_rd = alu_rs - alu_rt;
      3'b010: alu_rd = alu_rs & alu_rt;
      3'b011: alu_rd = alu_rs ^ alu_rt;
      3'b100: alu_rd = {alu_rs[2:0], alu_rs[3]};
      3'b101: alu_rd = {alu_rt[0], alu_rt[3:1]};
      3'b110: alu_rd = (alu_rs == alu_rt) ? 4'hF : 4'h0;
      3'b111: alu_rd = alu_rs | alu_rt;
      default: alu_rd = '0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] ins(input logic [2:0] s, input logic [1:0] d,
                                     input logic [1:0] a, input logic [1:0] b);
    return {s, d, a, b};
  endfunction

  task automatic reset_dut();
    @(negedge CLK);
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    rst_n = 1'b1;
  endtask

  task automatic load_instr(input int a, input logic [8:0] d);
    @(negedge CLK);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = d;
    @(negedge CLK);
    prog_we = 1'b0;
  endtask

  task automatic load_reg(input int idx, input logic [3:0] v);
    @(negedge CLK);
    reg_we = 1'b1; reg_waddr = idx[1:0]; reg_wdata = v;
    @(negedge CLK);
    reg_we = 1'b0;
  endtask

  task automatic read_reg(input int idx, output logic [3:0] v);
    dbg_addr = idx[1:0];
    #1;
    v = dbg_data;
  endtask

  // cyc counts cycles from the start cycle (cycle 0) to the cycle where done is seen.
  task automatic wait_done(inout int cyc);
    while (!done && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic run(input int n, output int cyc);
    @(negedge CLK);
    start = 1'b1; prog_len = n[4:0];
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    wait_done(cyc);
  endtask

  logic [3:0] v;
  int cyc;

  initial begin
    // 1: reset state and single add
    reset_dut();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sel", alu_sel, 0);
    check("rst_rs", alu_rs, 0);
    check("rst_rt", alu_rt, 0);
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      check($sformatf("rst_r%0d", i), v, 0);
    end
    load_reg(0, 4'd3);
    load_reg(1, 4'd5);
    load_instr(0, ins(3'b000, 2'd2, 2'd0, 2'd1));
    run(1, cyc);
    check("t1_cycles", cyc, 4);
    check("t1_sel", alu_sel, 0);
    check("t1_rs", alu_rs, 3);
    check("t1_rt", alu_rt, 5);
    read_reg(2, v); check("t1_r2", v, 8);
    @(negedge CLK);
    check("t1_done_pulse", done, 0);
    check("t1_busy_after", busy, 0);

    // 2: subtract wrap, then equality
    reset_dut();
    load_reg(0, 4'd2);
    load_reg(1, 4'd5);
    load_instr(0, ins(3'b001, 2'd3, 2'd0, 2'd1));
    load_instr(1, ins(3'b110, 2'd2, 2'd3, 2'd3));
    run(2, cyc);
    check("t2_cycles", cyc, 7);
    read_reg(3, v); check("t2_r3", v, 4'hD);
    read_reg(2, v); check("t2_r2", v, 4'hF);

    // 3: back-to-back dependency on r0
    reset_dut();
    load_reg(0, 4'd1);
    for (int i = 0; i < 8; i++) load_instr(i, ins(3'b000, 2'd0, 2'd0, 2'd0));
    run(3, cyc);
    read_reg(0, v); check("t3_r0_after3", v, 8);
    load_reg(0, 4'd1);
    run(8, cyc);
    check("t3_cycles", cyc, 25);
    read_reg(0, v); check("t3_r0_after8", v, 0);

    // 4: rotates and or
    reset_dut();
    load_reg(1, 4'b1001);
    load_instr(0, ins(3'b100, 2'd2, 2'd1, 2'd0));
    load_instr(1, ins(3'b101, 2'd3, 2'd0, 2'd1));
    load_instr(2, ins(3'b111, 2'd0, 2'd1, 2'd2));
    run(3, cyc);
    read_reg(2, v); check("t4_r2", v, 4'b0011);
    read_reg(3, v); check("t4_r3", v, 4'b1100);
    read_reg(0, v); check("t4_r0", v, 4'b1011);
    check("t4_sel_hold", alu_sel, 3'b111);
    check("t4_rs_hold", alu_rs, 4'b1001);
    check("t4_rt_hold", alu_rt, 4'b0011);

    // 5a: zero-length run leaves registers alone
    run(0, cyc);
    check("t5_len0_cycles", cyc, 1);
    read_reg(0, v); check("t5_len0_r0", v, 4'b1011);
    read_reg(3, v); check("t5_len0_r3", v, 4'b1100);

    // 5b: start / prog_we / reg_we while busy are ignored
    reset_dut();
    load_reg(0, 4'd1);
    load_reg(1, 4'd2);
    load_instr(0, ins(3'b000, 2'd2, 2'd0, 2'd1));
    load_instr(1, ins(3'b000, 2'd3, 2'd2, 2'd2));
    @(negedge CLK);
    start = 1'b1; prog_len = 5'd2;
    @(negedge CLK);
    start = 1'b0;
    cyc = 1;
    check("t5_busy_run", busy, 1);
    start = 1'b1; prog_len = 5'd1;
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = ins(3'b001, 2'd3, 2'd2, 2'd2);
    reg_we = 1'b1; reg_waddr = 2'd0; reg_wdata = 4'd7;
    @(negedge CLK);
    cyc++;
    start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
    wait_done(cyc);
    check("t5_busy_start_cycles", cyc, 7);
    read_reg(2, v); check("t5_ign_r2", v, 3);
    read_reg(3, v); check("t5_ign_r3", v, 6);
    repeat (3) @(negedge CLK);
    check("t5_no_restart", busy, 0);

    // 5c: program write and start in the same idle cycle
    reset_dut();
    load_reg(0, 4'd4);
    load_reg(1, 4'd1);
    @(negedge CLK);
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = ins(3'b001, 2'd2, 2'd0, 2'd1);
    start = 1'b1; prog_len = 5'd1;
    @(negedge CLK);
    prog_we = 1'b0; start = 1'b0;
    cyc = 1;
    wait_done(cyc);
    check("t5_wr_start_cycles", cyc, 4);
    read_reg(2, v); check("t5_wr_start_r2", v, 3);

    // 5d: prog_len above DEPTH clamps to 16 instructions
    reset_dut();
    load_reg(0, 4'd1);
    for (int i = 0; i < 16; i++) load_instr(i, ins(3'b000, 2'd1, 2'd1, 2'd0));
    run(20, cyc);
    check("t5_clamp_cycles", cyc, 49);
    read_reg(1, v); check("t5_clamp_r1", v, 0);
    run(1, cyc);
    read_reg(1, v); check("t5_pc_restart_r1", v, 1);

    // 5e: reset in the middle of a run
    @(negedge CLK);
    start = 1'b1; prog_len = 5'd8;
    @(negedge CLK);
    start = 1'b0;
    repeat (4) @(negedge CLK);
    rst_n = 1'b0;
    #1;
    check("t5_mid_busy", busy, 0);
    check("t5_mid_done", done, 0);
    check("t5_mid_rs", alu_rs, 0);
    for (int i = 0; i < 4; i++) begin
      read_reg(i, v);
      check($sformatf("t5_mid_r%0d", i), v, 0);
    end
    @(negedge CLK);
    check("t5_mid_no_done", done, 0);
    rst_n = 1'b1;
    @(negedge CLK);
    check("t5_mid_idle", busy, 0);

`ifdef SINGLE_STEP_EN
    // 6: single step holds after each writeback
    reset_dut();
    load_reg(0, 4'd1);
    load_reg(1, 4'd2);
    load_instr(0, ins(3'b000, 2'd2, 2'd0, 2'd1));
    load_instr(1, ins(3'b000, 2'd3, 2'd2, 2'd2));
    @(negedge CLK);
    start = 1'b1; prog_len = 5'd2;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    check("t6_stall_busy", busy, 1);
    read_reg(2, v); check("t6_first_r2", v, 3);
    read_reg(3, v); check("t6_second_pending", v, 0);
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
    repeat (6) @(negedge CLK);
    check("t6_stall2_busy", busy, 1);
    read_reg(3, v); check("t6_second_r3", v, 6);
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
    cyc = 0;
    wait_done(cyc);
    check("t6_done", done, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
